cache_arbiter: RTL
==================

Name: cache_arbiter

Overview:
- Sits directly downstream of the pipeline's instruction and data caches.
- Serializes their line-fill and write-back requests onto the single physical-memory port.
- Each granted request becomes exactly one memory transaction; the response is returned to the requester as a one-cycle pulse.
- Ties between the two caches are resolved round-robin, so the D-side (MEM stage) cannot starve instruction fetch, or vice versa.

Parameters:
- LINE_WIDTH, 256, cache line width in bits.
- ADDR_WIDTH, 32, byte address width.
- OFFSET_BITS, 5, line-offset bits; these are forced to zero on mem_addr.

Ports:
- clk  in  1  single clock.
- rst  in  1  asynchronous, active-low reset.
- i_read  in  1  I-cache line-fill request; held until i_resp.
- i_addr  in  ADDR_WIDTH  I-cache line address.
- i_rdata  out  LINE_WIDTH  fill data returned to the I-cache; valid while i_resp=1.
- i_resp  out  1  one-cycle completion pulse to the I-cache.
- d_read  in  1  D-cache line-fill request; held until d_resp.
- d_write  in  1  D-cache write-back request; held until d_resp.
- d_addr  in  ADDR_WIDTH  D-cache line address.
- d_wdata  in  LINE_WIDTH  write-back data.
- d_rdata  out  LINE_WIDTH  fill data returned to the D-cache; valid while d_resp=1.
- d_resp  out  1  one-cycle completion pulse to the D-cache.
- mem_read  out  1  memory read request; held until mem_resp.
- mem_write  out  1  memory write request; held until mem_resp.
- mem_addr  out  ADDR_WIDTH  line-aligned memory address.
- mem_wdata  out  LINE_WIDTH  memory write data.
- mem_rdata  in  LINE_WIDTH  memory read data; valid with mem_resp.
- mem_resp  in  1  memory completion pulse.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, last_grant=I.
  - All outputs 0, including the rdata buffers, mem_addr and mem_wdata.
- States: IDLE, BUSY_I, BUSY_D, RESP_I, RESP_D.
- IDLE transitions:
  - If a D request (d_read|d_write) and an I request are both pending: grant D when last_grant=I, otherwise grant I.
  - If only one request is pending, grant it.
  - If none is pending, stay in IDLE.
  - On grant, register the address (low OFFSET_BITS zeroed), the op and d_wdata.
  - Next state is BUSY_I or BUSY_D; last_grant is updated.
- BUSY_x:
  - mem_read or mem_write is driven from registered state only, never combinationally from requester inputs.
  - It asserts the cycle after the grant and is held until mem_resp.
  - mem_addr and mem_wdata are stable throughout.
  - On mem_resp, capture mem_rdata into the line buffer; next state is RESP_x.
- RESP_x:
  - x_resp=1 for exactly one cycle.
  - x_rdata = buffer; the buffer holds its value afterwards until the next capture.
  - The matching mem request is deasserted.
  - Next state is IDLE.
  - Because a request is never sampled in RESP, a held request that the requester drops after seeing resp cannot be reissued.
- Latency: request sampled in IDLE at cycle n -> mem_* asserted at n+1 -> mem_resp at cycle m -> x_resp at m+1. Minimum round trip is 3 cycles plus memory latency.
- d_read and d_write both high: illegal input; the write takes precedence and mem_write is issued.
- Requester deasserts mid-transaction: ignored; the transaction completes and the resp pulse is still emitted.
- mem_resp outside BUSY: ignored.
- Reset mid-transaction: return immediately to IDLE with outputs 0; the memory side must tolerate the abandoned request.
- Arbitration is not preemptive: a request arriving during BUSY waits for IDLE.
- At most one of mem_read/mem_write is high, and at most one of i_resp/d_resp is high, in any cycle.

Decomposition:
- Shared package cache_arb_types:
  - arb_state_t enum (IDLE, BUSY_I, BUSY_D, RESP_I, RESP_D).
  - grant_t enum (GRANT_I, GRANT_D).
  - Line typedef logic [LINE_WIDTH-1:0].
- Single module; the line buffer and the address/wdata registers use the existing parameterized register.
- No further sub-module is warranted.

Test Plan:
- Lone I fill: i_read=1, i_addr=0x0000_0064, mem_resp 4 cycles after mem_read -> mem_read at n+1 with mem_addr=0x0000_0060; i_resp pulse for one cycle with i_rdata=mem_rdata; d_resp stays 0.
- D write-back: d_write=1, d_addr=0x8000_0020, d_wdata=0xA5 repeated -> mem_write=1, mem_addr=0x8000_0020, mem_wdata=0xA5.., mem_read=0; d_resp one cycle after mem_resp.
- Simultaneous requests from reset: i_read and d_read both asserted and held -> D served first, then I; grants alternate D, I, D, I over 4 transactions with both held.
- Request dropped mid-BUSY: i_read falls 1 cycle after grant -> mem_read stays high until mem_resp; i_resp still pulses once; no second transaction issued.
- Async reset in BUSY_D: rst low mid-cycle -> all outputs 0 immediately; after release with no requests, state stays IDLE and mem_read=mem_write=0.
- Illegal d_read=d_write=1 -> mem_write issued, mem_read=0, single d_resp.

Source files
------------

// File: rtl/cache_arb_types.sv
// Shared types for the I/D cache to physical-memory arbiter.
package cache_arb_types;

  localparam int CA_LINE_WIDTH  = 256;
  localparam int CA_ADDR_WIDTH  = 32;
  localparam int CA_OFFSET_BITS = 5;

  typedef enum logic [2:0] {
    IDLE,
    BUSY_I,
    BUSY_D,
    RESP_I,
    RESP_D
  } arb_state_t;

  typedef enum logic {
    GRANT_I,
    GRANT_D
  } grant_t;

  typedef logic [CA_LINE_WIDTH-1:0] line_t;

endpackage

// File: rtl/cache_arb_reg.sv
// Parameterized load-enable register with asynchronous active-low clear.
module cache_arb_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/cache_arbiter.sv
// Round-robin arbiter serializing I-cache fills and D-cache fills/write-backs
// onto a single physical-memory port, one transaction per grant.
//
// state  | meaning
// IDLE   | sample requests, grant one (round-robin on a tie)
// BUSY_I | I-cache fill outstanding on the memory port
// BUSY_D | D-cache fill or write-back outstanding on the memory port
// RESP_I | one-cycle i_resp pulse, fill data presented on i_rdata
// RESP_D | one-cycle d_resp pulse, fill data presented on d_rdata
module cache_arbiter
  import cache_arb_types::*;
#(
  parameter int LINE_WIDTH  = CA_LINE_WIDTH,
  parameter int ADDR_WIDTH  = CA_ADDR_WIDTH,
  parameter int OFFSET_BITS = CA_OFFSET_BITS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_read,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  output logic [LINE_WIDTH-1:0] i_rdata,
  output logic                  i_resp,
  input  logic                  d_read,
  input  logic                  d_write,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [LINE_WIDTH-1:0] d_wdata,
  output logic [LINE_WIDTH-1:0] d_rdata,
  output logic                  d_resp,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [LINE_WIDTH-1:0] mem_wdata,
  input  logic [LINE_WIDTH-1:0] mem_rdata,
  input  logic                  mem_resp
);

  arb_state_t state_q, state_d;
  grant_t     last_q, last_d;

  logic                  load;
  logic                  load_d;
  logic                  capture;
  logic                  d_req;
  logic [ADDR_WIDTH-1:0] addr_sel;
  logic [ADDR_WIDTH-1:0] addr_aligned;
  logic                  write_q;
  logic [LINE_WIDTH-1:0] line_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      last_q  <= GRANT_I;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
    end
  end

  assign d_req = d_read | d_write;

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    load    = 1'b0;
    load_d  = 1'b0;
    capture = 1'b0;
    case (state_q)
      IDLE: begin
        // D wins a tie only when I had the previous grant.
        if (d_req && (!i_read || last_q == GRANT_I)) begin
          state_d = BUSY_D;
          last_d  = GRANT_D;
          load    = 1'b1;
          load_d  = 1'b1;
        end else if (i_read) begin
          state_d = BUSY_I;
          last_d  = GRANT_I;
          load    = 1'b1;
        end
      end
      BUSY_I: begin
        if (mem_resp) begin
          capture = 1'b1;
          state_d = RESP_I;
        end
      end
      BUSY_D: begin
        if (mem_resp) begin
          capture = 1'b1;
          state_d = RESP_D;
        end
      end
      RESP_I:  state_d = IDLE;
      RESP_D:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign addr_sel     = load_d ? d_addr : i_addr;
  assign addr_aligned = {addr_sel[ADDR_WIDTH-1:OFFSET_BITS], {OFFSET_BITS{1'b0}}};

  cache_arb_reg #(.WIDTH(ADDR_WIDTH)) u_addr_reg (
    .clk   (clk),
    .rst_n (rst),
    .en    (load),
    .d     (addr_aligned),
    .q     (mem_addr)
  );

  // An I grant always loads a read; d_write dominates d_read on the D side.
  cache_arb_reg #(.WIDTH(1)) u_op_reg (
    .clk   (clk),
    .rst_n (rst),
    .en    (load),
    .d     (load_d & d_write),
    .q     (write_q)
  );

  cache_arb_reg #(.WIDTH(LINE_WIDTH)) u_wdata_reg (
    .clk   (clk),
    .rst_n (rst),
    .en    (load_d),
    .d     (d_wdata),
    .q     (mem_wdata)
  );

  cache_arb_reg #(.WIDTH(LINE_WIDTH)) u_line_buf (
    .clk   (clk),
    .rst_n (rst),
    .en    (capture),
    .d     (mem_rdata),
    .q     (line_q)
  );

  assign mem_read  = (state_q == BUSY_I) | ((state_q == BUSY_D) & ~write_q);
  assign mem_write = (state_q == BUSY_D) & write_q;
  assign i_resp    = (state_q == RESP_I);
  assign d_resp    = (state_q == RESP_D);
  assign i_rdata   = line_q;
  assign d_rdata   = line_q;

endmodule
